// File: rtl/hex_7seg_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with double-buffered display value.
// Optional leading-zero blanking: define HEX_7SEG_LEADING_ZERO_BLANK_EN.
module hex_7seg_scan_driver #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 1000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dots,
   output logic [6:0]              seg,
   output logic                    dot,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_done
);

   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] pend_val;
   logic [4*NUM_DIGITS-1:0] act_val;
   logic [NUM_DIGITS-1:0]   pend_dots;
   logic [NUM_DIGITS-1:0]   act_dots;
   logic                    pend_valid;
   logic                    wrap;
   logic                    wrap_q;
   logic [3:0]              nib;
   logic                    nib_dot;
   logic [6:0]              seg_next;

   function automatic logic [6:0] decode(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1111110;
         4'h1: s = 7'b0110000;
         4'h2: s = 7'b1101101;
         4'h3: s = 7'b1111001;
         4'h4: s = 7'b0110011;
         4'h5: s = 7'b1011011;
         4'h6: s = 7'b1011111;
         4'h7: s = 7'b1110000;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1111011;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b0011111;
         4'hC: s = 7'b1001110;
         4'hD: s = 7'b0111101;
         4'hE: s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   // Frame boundary: last prescaler count of the last digit.
   always_comb begin
      wrap = enable && (presc == PRESC_LAST) && (idx == IDX_LAST);
   end

   always_comb begin
      nib     = '0;
      nib_dot = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            nib     = act_val[4*i +: 4];
            nib_dot = act_dots[i];
         end
      end
   end

`ifdef HEX_7SEG_LEADING_ZERO_BLANK_EN
   logic blank;

   // Digit i is a leading zero when the value shifted down by i nibbles is zero.
   always_comb begin
      blank = 1'b0;
      for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
         if ((idx == IW'(i)) && ((act_val >> (4*i)) == '0)) blank = 1'b1;
      end
   end

   always_comb begin
      seg_next = blank ? '0 : decode(nib);
   end
`else
   always_comb begin
      seg_next = decode(nib);
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc      <= '0;
         idx        <= '0;
         pend_val   <= '0;
         pend_dots  <= '0;
         pend_valid <= 1'b0;
         act_val    <= '0;
         act_dots   <= '0;
         wrap_q     <= 1'b0;
         seg        <= '0;
         dot        <= 1'b0;
         digit_sel  <= '0;
         frame_done <= 1'b0;
      end else begin
         if (!enable) begin
            presc <= '0;
            idx   <= '0;
         end else if (presc == PRESC_LAST) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
         end else begin
            presc <= presc + PW'(1);
         end

         // A load on the boundary still refills pending; the transfer takes the old pending data.
         if (wrap && pend_valid) begin
            act_val  <= pend_val;
            act_dots <= pend_dots;
         end
         if (load) begin
            pend_val   <= value;
            pend_dots  <= dots;
            pend_valid <= 1'b1;
         end else if (wrap) begin
            pend_valid <= 1'b0;
         end

         wrap_q <= wrap;
         if (enable) begin
            seg        <= seg_next;
            dot        <= nib_dot;
            digit_sel  <= NUM_DIGITS'(1) << idx;
            frame_done <= wrap_q;
         end else begin
            seg        <= '0;
            dot        <= 1'b0;
            digit_sel  <= '0;
            frame_done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hex_7seg_scan_driver.sv
// Directed bench for hex_7seg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_hex_7seg_scan_driver;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dots;
   logic [6:0]  seg;
   logic        dot;
   logic [3:0]  digit_sel;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   hex_7seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .load       (load),
      .value      (value),
      .dots       (dots),
      .seg        (seg),
      .dot        (dot),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0]     value;
      logic [3:0]      dots;
      logic [3:0][6:0] segs;   // segs[i] is the expected pattern of digit i
   } vec_t;

   vec_t vecs[5];

   localparam logic [6:0] S0 = 7'b1111110;
   localparam logic [6:0] S1 = 7'b0110000;
   localparam logic [6:0] S2 = 7'b1101101;
   localparam logic [6:0] S4 = 7'b0110011;
   localparam logic [6:0] S5 = 7'b1011011;
   localparam logic [6:0] S7 = 7'b1110000;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic chk_blank(input string tag);
      chk({tag, " digit_sel"}, 32'(digit_sel), 32'h0);
      chk({tag, " seg"}, 32'(seg), 32'h0);
      chk({tag, " dot"}, 32'(dot), 32'h0);
      chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
   endtask

   // Checks output cycles k=start_k..15 of a frame; caller is sampled at cycle start_k.
   task automatic check_frame_from(input string tag, input int start_k,
                                   input logic [3:0][6:0] segs, input logic [3:0] dts,
                                   input logic fd_first);
      for (int k = start_k; k < 16; k++) begin
         int d;
         if (k != start_k) tick();
         d = k / 4;
         chk($sformatf("%s k%0d digit_sel", tag, k), 32'(digit_sel), 32'(4'b0001 << d));
         chk($sformatf("%s k%0d seg", tag, k), 32'(seg), 32'(segs[d]));
         chk($sformatf("%s k%0d dot", tag, k), 32'(dot), 32'(dts[d]));
         chk($sformatf("%s k%0d frame_done", tag, k), 32'(frame_done),
             32'((k == 0) ? fd_first : 1'b0));
      end
   endtask

   task automatic wait_fd();
      int n = 0;
      do begin
         tick();
         n++;
      end while (frame_done !== 1'b1 && n < 40);
      if (frame_done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_frame_done actual %b required 1 within 40 cycles", frame_done);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dots  = d;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   initial begin
      vecs[0] = '{16'h3A7F, 4'b0100, {7'b1111001, 7'b1110111, 7'b1110000, 7'b1000111}};
      vecs[1] = '{16'h1230, 4'b0001, {7'b0110000, 7'b1101101, 7'b1111001, 7'b1111110}};
      vecs[2] = '{16'h4567, 4'b1010, {7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000}};
      vecs[3] = '{16'h89AB, 4'b1000, {7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111}};
      vecs[4] = '{16'hCDEF, 4'b1111, {7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111}};

      reset_n = 1'b0;
      enable  = 1'b0;
      load    = 1'b0;
      value   = '0;
      dots    = '0;

      // Reset state and first frame
      repeat (2) tick();
      chk_blank("reset");
      reset_n = 1'b1;
      tick();
      chk_blank("disabled_after_reset");
      enable = 1'b1;
      tick();
      check_frame_from("first_frame", 0, {4{S0}}, 4'b0000, 1'b0);
      tick();
      check_frame_from("second_frame", 0, {4{S0}}, 4'b0000, 1'b1);

      // Decode and full-scan table
      for (int r = 0; r < 5; r++) begin
         wait_fd();
         do_load(vecs[r].value, vecs[r].dots);
         wait_fd();
         check_frame_from($sformatf("vec%0d", r), 0, vecs[r].segs, vecs[r].dots, 1'b1);
      end

      // Tear-free update: second load while digit 2 is lit
      wait_fd();
      do_load(16'h1111, 4'b0000);
      wait_fd();
      repeat (8) tick();
      do_load(16'h2222, 4'b0000);
      check_frame_from("tear_old", 9, {4{S1}}, 4'b0000, 1'b1);
      tick();
      check_frame_from("tear_new", 0, {4{S2}}, 4'b0000, 1'b1);

      // Load in the wrap cycle with 0x1111 pending
      tick();
      do_load(16'h1111, 4'b0000);
      repeat (13) tick();
      do_load(16'h5555, 4'b0000);
      tick();
      check_frame_from("boundary_old", 0, {4{S1}}, 4'b0000, 1'b1);
      tick();
      check_frame_from("boundary_new", 0, {4{S5}}, 4'b0000, 1'b1);

      // Enable toggle mid-digit; a load while disabled is held in pending
      tick();
      repeat (5) tick();
      enable = 1'b0;
      tick();
      chk_blank("disable_1cyc");
      do_load(16'h7777, 4'b0000);
      repeat (20) tick();
      chk_blank("disable_hold");
      enable = 1'b1;
      tick();
      check_frame_from("reenable", 0, {4{S5}}, 4'b0000, 1'b0);
      tick();
      check_frame_from("reenable_next", 0, {4{S7}}, 4'b0000, 1'b1);

      // Leading-zero handling of 0x0040
      wait_fd();
      do_load(16'h0040, 4'b0000);
      wait_fd();
`ifdef HEX_7SEG_LEADING_ZERO_BLANK_EN
      check_frame_from("blank", 0, {7'b0000000, 7'b0000000, S4, S0}, 4'b0000, 1'b1);
`else
      check_frame_from("blank", 0, {S0, S0, S4, S0}, 4'b0000, 1'b1);
`endif

      // Asynchronous reset mid-scan
      repeat (6) tick();
      reset_n = 1'b0;
      #2;
      chk_blank("async_reset");
      tick();
      chk_blank("reset_held");
      reset_n = 1'b1;
      tick();
      chk("after_reset digit_sel", 32'(digit_sel), 32'h1);
      chk("after_reset seg", 32'(seg), 32'(S0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
